posit_prod_buffer: RTL and testbench
====================================

# posit_prod_buffer

Elastic output buffer directly downstream of the posit multiplier in the Pair-HMM datapath. Captures each `{result, inf, zero}` triple the multiplier presents with `done`, canonicalises special values, and holds it in a first-word-fall-through FIFO until the consumer (the accumulation stage) takes it with a valid/ready handshake. Optionally keeps saturating event statistics for debug readout.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `NBITS`, 32, posit width; must equal the package `NBITS`.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  product present; driven by the multiplier `done`.
- `in_result`  in  NBITS  product posit.
- `in_inf`  in  1  product is NaR.
- `in_zero`  in  1  product is zero.
- `in_ready`  out  1  buffer can accept this cycle.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer takes the head entry.
- `out_result`  out  NBITS  head posit.
- `out_inf`  out  1  head is NaR.
- `out_zero`  out  1  head is zero.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: a product was offered while the buffer was full.
- `clear_stats`  in  1  synchronous clear of `overflow` and the statistics counters.
- `stat_total`, `stat_inf`, `stat_zero`  out  16 each  present only with the statistics macro defined (see Configuration).

## Operation
- Push = `in_valid & in_ready`. Pop = `out_valid & out_ready`.
- `in_ready = (level != DEPTH)`. `out_valid = (level != 0)`. Both are combinational from registered state only; neither depends on `in_valid` or `out_ready`.
- Occupancy states:
  - EMPTY (`level = 0`): only a push is possible.
  - PARTIAL: push and pop may coincide; `level` is unchanged and both pointers advance.
  - FULL (`level = DEPTH`): `in_ready = 0`. A push is refused even if a pop occurs in the same cycle; there is no pass-through.
- Canonicalisation is applied on write:
  - `in_inf = 1`: store result `{1'b1, {NBITS-1{1'b0}}}` with inf = 1, zero = 0. NaR wins if both flags are set.
  - else `in_zero = 1`: store result 0 with zero = 1.
  - else: store `in_result` unchanged.
- Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `level` is a separate counter.
- Overflow: `in_valid & ~in_ready` sets `overflow`. The product is dropped; the multiplier has no stall path, so loss is flagged rather than prevented.
- `clear_stats` clears `overflow` next edge. It has priority over a simultaneous set.

## Timing
- Reset (async assert, sync release): pointers 0, `level` 0, `out_valid` 0, `in_ready` 1, `overflow` 0, all counters 0, `out_result`/`out_inf`/`out_zero` 0.
- Latency: a product pushed at edge N appears on `out_*` with `out_valid = 1` immediately after edge N, i.e. one cycle.
- Throughput: one push and one pop per cycle sustained.
- FIFO storage contents are not reset. While `out_valid = 0`, the head data outputs are masked to 0.
- Reset asserted mid-stream discards all entries. No handshake completes in the reset cycle.

## Configuration
- `POSIT_PROD_STATS_EN` defined:
  - 16-bit saturating counters, each incremented on push:
    - `stat_total`: every push.
    - `stat_inf`: canonical NaR pushes.
    - `stat_zero`: canonical zero pushes; a NaR with `in_zero` set is counted only as NaR.
  - Counters hold at 16'hFFFF.
  - `clear_stats` zeroes them and has priority over a simultaneous increment.
- Macro undefined: the three stat ports and counters are absent. `clear_stats` clears only `overflow`.

## Structure
- `posit_defines` package: `NBITS`, a `prod_entry` struct `{result, inf, zero}`, and a NaR constant.
- One sub-module, `posit_prod_canon`: combinational canonicalisation of an incoming triple into a `prod_entry`.
- FIFO storage, pointers, occupancy and stats live in the top module.

## Test plan
- Reset, then push 0x40000000 with `out_ready = 0` -> `out_valid` = 1 the next cycle, `out_result` = 0x40000000, `level` = 1.
- Push 16 products with `out_ready = 0` -> `level` = 16, `in_ready` = 0; a 17th `in_valid` sets `overflow` and the product is dropped. Then pop all -> original order, `level` = 0.
- Full buffer with push and pop in the same cycle -> the push is refused, `level` = 15.
- Push `in_inf = 1, in_zero = 1, in_result = 0x12345678` -> head shows 0x80000000 with inf = 1, zero = 0; `stat_inf` increments and `stat_zero` does not.
- Continuous push/pop for 70000 cycles with the stats macro defined -> `stat_total` saturates at 0xFFFF; `clear_stats` together with a push -> counters read 0.
- Assert `rst_n` low with 5 entries held -> `level` = 0, `out_valid` = 0, `overflow` = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/posit_prod_buffer_pkg.sv
// Shared definitions for the posit product buffer: posit width, the stored
// entry layout and the NaR encoding.
package posit_defines;

  localparam int NBITS = 32;

  // One buffered product after canonicalisation.
  typedef struct packed {
    logic [NBITS-1:0] result;
    logic             inf;
    logic             zero;
  } prod_entry;

  // Posit NaR: sign bit set, every other bit clear.
  localparam logic [NBITS-1:0] NAR = {1'b1, {(NBITS-1){1'b0}}};

  // Fold the multiplier flags into one canonical entry. NaR outranks zero,
  // so a product flagged as both is stored and reported as NaR only.
  function automatic prod_entry canon_entry(input logic [NBITS-1:0] result,
                                            input logic             inf,
                                            input logic             zero);
    prod_entry e;
    e.result = result;
    e.inf    = 1'b0;
    e.zero   = 1'b0;
    if (inf) begin
      e.result = NAR;
      e.inf    = 1'b1;
    end else if (zero) begin
      e.result = '0;
      e.zero   = 1'b1;
    end
    return e;
  endfunction

endpackage

// File: rtl/posit_prod_buffer_canon.sv
// posit_prod_canon: purely combinational clean-up of a raw multiplier
// triple {result, inf, zero} into the canonical form kept in the buffer.
module posit_prod_canon
  import posit_defines::*;
(
  input  logic [NBITS-1:0] in_result,
  input  logic             in_inf,
  input  logic             in_zero,
  output prod_entry        entry
);

  // Special values are rewritten to their single legal encoding.
  always_comb begin
    entry = canon_entry(in_result, in_inf, in_zero);
  end

endmodule

// File: rtl/posit_prod_buffer.sv
// posit_prod_buffer: elastic first-word-fall-through buffer behind the posit
// multiplier. Products are canonicalised on write and drained by the
// accumulation stage through a valid/ready handshake. A product offered
// while full is dropped and flagged in the sticky overflow bit, since the
// multiplier cannot be stalled.
//
// Optional macro POSIT_PROD_STATS_EN adds 16-bit saturating push counters
// (stat_total, stat_inf, stat_zero) for debug readout.
module posit_prod_buffer #(
  parameter int DEPTH = 16,
  parameter int NBITS = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [NBITS-1:0]           in_result,
  input  logic                       in_inf,
  input  logic                       in_zero,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NBITS-1:0]           out_result,
  output logic                       out_inf,
  output logic                       out_zero,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clear_stats
`ifdef POSIT_PROD_STATS_EN
  ,
  output logic [15:0]                stat_total,
  output logic [15:0]                stat_inf,
  output logic [15:0]                stat_zero
`endif
);

  import posit_defines::*;

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  prod_entry         mem [DEPTH];
  prod_entry         wr_entry;
  prod_entry         head;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  posit_prod_canon u_canon (
    .in_result (in_result),
    .in_inf    (in_inf),
    .in_zero   (in_zero),
    .entry     (wr_entry)
  );

  // Handshake flags come only from the registered occupancy; a full buffer
  // refuses a push even when a pop happens in the same cycle.
  always_comb begin
    in_ready  = (level != FULL_LEVEL);
    out_valid = (level != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Head data is masked to zero whenever no entry is valid.
  always_comb begin
    head       = mem[rd_ptr];
    out_result = out_valid ? head.result : '0;
    out_inf    = out_valid & head.inf;
    out_zero   = out_valid & head.zero;
  end

  // Storage array is deliberately left unreset; validity is tracked by level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers wrap naturally at DEPTH; level is kept as a separate counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky loss flag; a clear request wins over a same-cycle new loss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clear_stats) begin
      overflow <= 1'b0;
    end else if (in_valid && !in_ready) begin
      overflow <= 1'b1;
    end
  end

`ifdef POSIT_PROD_STATS_EN
  // Saturating push statistics, classified by the canonical entry so a
  // product flagged as both NaR and zero counts only as NaR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_total <= '0;
      stat_inf   <= '0;
      stat_zero  <= '0;
    end else if (clear_stats) begin
      stat_total <= '0;
      stat_inf   <= '0;
      stat_zero  <= '0;
    end else if (push) begin
      if (stat_total != 16'hFFFF) begin
        stat_total <= stat_total + 16'd1;
      end
      if (wr_entry.inf && stat_inf != 16'hFFFF) begin
        stat_inf <= stat_inf + 16'd1;
      end
      if (wr_entry.zero && stat_zero != 16'hFFFF) begin
        stat_zero <= stat_zero + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_posit_prod_buffer.sv
// Self-checking bench for posit_prod_buffer. Stimulus is applied one cycle
// at a time; accepted products are queued as expected entries and a monitor
// on the falling edge compares the DUT head, occupancy and flags against
// that queue. Build with POSIT_PROD_STATS_EN to also cover the counters.
module tb_posit_prod_buffer;

  localparam int DEPTH = 16;
  localparam int NBITS = 32;

  typedef struct {
    logic [31:0] result;
    logic        inf;
    logic        zero;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_result;
  logic        in_inf;
  logic        in_zero;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_inf;
  logic        out_zero;
  logic [4:0]  level;
  logic        overflow;
  logic        clear_stats;
`ifdef POSIT_PROD_STATS_EN
  logic [15:0] stat_total;
  logic [15:0] stat_inf;
  logic [15:0] stat_zero;
  int          m_total;
  int          m_inf;
  int          m_zero;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  logic m_ovf = 1'b0;
  int   sz;
  exp_t e;

  posit_prod_buffer #(.DEPTH(DEPTH), .NBITS(NBITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_result   (in_result),
    .in_inf      (in_inf),
    .in_zero     (in_zero),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_inf     (out_inf),
    .out_zero    (out_zero),
    .level       (level),
    .overflow    (overflow),
    .clear_stats (clear_stats)
`ifdef POSIT_PROD_STATS_EN
    ,
    .stat_total  (stat_total),
    .stat_inf    (stat_inf),
    .stat_zero   (stat_zero)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference rule for what the buffer should store for a raw triple.
  function automatic exp_t ref_canon(input logic [31:0] r, input logic inf, input logic zero);
    exp_t x;
    if (inf) begin
      x.result = 32'h8000_0000; x.inf = 1'b1; x.zero = 1'b0;
    end else if (zero) begin
      x.result = 32'h0; x.inf = 1'b0; x.zero = 1'b1;
    end else begin
      x.result = r; x.inf = 1'b0; x.zero = 1'b0;
    end
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] r, input logic inf,
                               input logic zero, input logic ordy, input logic clr);
    @(posedge clk);
    #1;
    in_valid    = v;
    in_result   = r;
    in_inf      = inf;
    in_zero     = zero;
    out_ready   = ordy;
    clear_stats = clr;
  endtask

  task automatic idleInputs();
    in_valid = 1'b0; in_result = '0; in_inf = 1'b0; in_zero = 1'b0;
    out_ready = 1'b0; clear_stats = 1'b0;
  endtask

  task automatic resetModel();
    exp_q.delete();
    m_ovf = 1'b0;
`ifdef POSIT_PROD_STATS_EN
    m_total = 0; m_inf = 0; m_zero = 0;
`endif
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    idleInputs();
    rst_n = 1'b0;
    resetModel();
    #1;
    checkOutput("reset_level", 32'(level), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    checkOutput("reset_out_result", out_result, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: compare what the DUT presents against the expected queue, then
  // advance the model by whatever the coming rising edge will do.
  always @(negedge clk) begin
    if (rst_n) begin
      sz = exp_q.size();
      checkOutput("level", 32'(level), 32'(sz));
      checkOutput("out_valid", 32'(out_valid), 32'(sz != 0));
      checkOutput("in_ready", 32'(in_ready), 32'(sz != DEPTH));
      checkOutput("overflow", 32'(overflow), 32'(m_ovf));
      if (sz != 0) begin
        checkOutput("head_result", out_result, exp_q[0].result);
        checkOutput("head_inf", 32'(out_inf), 32'(exp_q[0].inf));
        checkOutput("head_zero", 32'(out_zero), 32'(exp_q[0].zero));
      end else begin
        checkOutput("masked_result", out_result, 32'd0);
        checkOutput("masked_flags", {30'd0, out_inf, out_zero}, 32'd0);
      end
`ifdef POSIT_PROD_STATS_EN
      checkOutput("stat_total", 32'(stat_total), 32'(m_total));
      checkOutput("stat_inf", 32'(stat_inf), 32'(m_inf));
      checkOutput("stat_zero", 32'(stat_zero), 32'(m_zero));
`endif
      if (sz != 0 && out_ready) begin
        void'(exp_q.pop_front());
      end
      if (in_valid && sz != DEPTH) begin
        e = ref_canon(in_result, in_inf, in_zero);
        exp_q.push_back(e);
      end
      if (clear_stats) m_ovf = 1'b0;
      else if (in_valid && sz == DEPTH) m_ovf = 1'b1;
`ifdef POSIT_PROD_STATS_EN
      if (clear_stats) begin
        m_total = 0; m_inf = 0; m_zero = 0;
      end else if (in_valid && sz != DEPTH) begin
        if (m_total < 65535) m_total++;
        if (e.inf && m_inf < 65535) m_inf++;
        if (e.zero && m_zero < 65535) m_zero++;
      end
`endif
    end
  end

  initial begin
    rst_n = 1'b0;
    idleInputs();
    resetModel();
    #3;
    doReset();

    // Single product, then hold.
    applyStimulus(1'b1, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill to full, offer one more (dropped, overflow), drain in order.
    for (int i = 1; i < DEPTH; i++)
      applyStimulus(1'b1, 32'h1000_0000 + i, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (DEPTH) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full buffer with simultaneous push and pop: push refused.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, 32'h2000_0000 + i, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (DEPTH) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // NaR with zero also set, then plain zero.
    applyStimulus(1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h5555_AAAA, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomised traffic with occasional special values and clears.
    for (int i = 0; i < 3000; i++)
      applyStimulus(1'($urandom_range(0, 99) < 60), $urandom(),
                    1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 63) == 0));

`ifdef POSIT_PROD_STATS_EN
    // Long sustained push/pop to saturate the total counter, then clear
    // together with a push.
    doReset();
    for (int i = 0; i < 66000; i++)
      applyStimulus(1'b1, $urandom(), 1'($urandom_range(0, 15) == 0), 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h3000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // Build up five entries with overflow set, then reset asynchronously.
    doReset();
    for (int i = 0; i < DEPTH + 1; i++)
      applyStimulus(1'b1, 32'h6000_0000 + i, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (DEPTH - 5) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("pre_reset_level", 32'(level), 32'd5);
    checkOutput("pre_reset_overflow", 32'(overflow), 32'd1);
    rst_n = 1'b0;
    resetModel();
    #1;
    checkOutput("async_reset_level", 32'(level), 32'd0);
    checkOutput("async_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_reset_overflow", 32'(overflow), 32'd0);
    #10;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
